pp_frame_gate: RTL and testbench

- AXI4-Stream frame sequencer upstream of the red-pixel detector: on a software arm it waits for start-of-frame and passes exactly one well-formed frame, or successive frames in continuous mode.
- Enforces IMG_W x IMG_H geometry, repairs long lines, flags malformed lines/frames and reports completion.
- Drops all traffic while idle so the detector only ever sees aligned frames.

---
 rtl/pp_pkg.sv | 16 +
 rtl/pp_frame_gate_if.sv | 35 +++
 rtl/pp_axis_reg_slice.sv | 47 ++++
 rtl/pp_frame_gate.sv | 159 +++++++++++++++
 tb/tb_pp_frame_gate.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pp_pkg.sv
// Shared constants and state encoding for the pre-processing frame path.
// The geometry defaults are shared with the red-pixel detector and downstream blocks.
package pp_pkg;

  localparam int PP_IMG_W  = 640;
  localparam int PP_IMG_H  = 480;
  localparam int PP_DATA_W = 32;

  typedef enum logic [1:0] {
    PP_IDLE     = 2'd0,
    PP_WAIT_SOF = 2'd1,
    PP_PASS     = 2'd2,
    PP_RESYNC   = 2'd3
  } pp_state_e;

endpackage

// File: rtl/pp_frame_gate_if.sv
// AXI4-Stream pair around the frame gate: s_* from the camera, m_* to the detector.
// Handshake: a beat transfers on a rising clock edge where tvalid && tready; the source holds payload stable while tvalid && !tready.
interface pp_frame_gate_if
  import pp_pkg::*;
#(
  parameter int DATA_W = PP_DATA_W
);

  logic              s_tvalid;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tuser;
  logic              s_tlast;
  logic              s_tready;

  logic              m_tvalid;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tuser;
  logic              m_tlast;
  logic              m_tready;

  modport slave (
    input  s_tvalid, s_tdata, s_tuser, s_tlast,
    output s_tready,
    output m_tvalid, m_tdata, m_tuser, m_tlast,
    input  m_tready
  );

  modport master (
    output s_tvalid, s_tdata, s_tuser, s_tlast,
    input  s_tready,
    input  m_tvalid, m_tdata, m_tuser, m_tlast,
    output m_tready
  );

endinterface

// File: rtl/pp_axis_reg_slice.sv
// Single-entry AXI4-Stream output register: one-cycle latency, payload held while stalled.
// The caller may only assert i_load when o_ready is high.
module pp_axis_reg_slice #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_user,
  input  logic         i_last,
  input  logic         i_ready,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_user,
  output logic         o_last
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_user;
  logic         r_last;

  assign o_ready = i_ready || !r_valid;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_user  = r_user;
  assign o_last  = r_last;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_user  <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_user  <= i_user;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pp_frame_gate.sv
// Frame sequencer in front of the red-pixel detector: after an arm it forwards whole
// IMG_W x IMG_H frames only, repairs long lines and flags malformed traffic.
module pp_frame_gate
  import pp_pkg::*;
#(
  parameter int IMG_W  = PP_IMG_W,
  parameter int IMG_H  = PP_IMG_H,
  parameter int DATA_W = PP_DATA_W
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  input  logic                  i_continuous,
  pp_frame_gate_if.slave        axis,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_err_short,
  output logic                  o_err_long,
  output logic                  o_err_sof,
  output logic [15:0]           o_frame_count,
  output logic [1:0]            o_dbg_state
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  localparam logic [1:0] ST_IDLE     = PP_IDLE;
  localparam logic [1:0] ST_WAIT_SOF = PP_WAIT_SOF;
  localparam logic [1:0] ST_PASS     = PP_PASS;
  localparam logic [1:0] ST_RESYNC   = PP_RESYNC;

  logic [1:0]       r_state, w_state_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt, w_col_eff;
  logic [ROW_W-1:0] r_row, w_row_nxt, w_row_eff;
  logic             r_frame_done, r_err_short, r_err_long, r_err_sof;
  logic [15:0]      r_frame_count;

  logic             w_fwd_cand, w_slice_ready, w_accept, w_load;
  logic             w_restart, w_eol, w_force_last, w_frame_end;
  logic             w_set_short, w_set_long, w_set_sof;
  logic             w_m_tvalid, w_m_tuser, w_m_tlast;
  logic [DATA_W-1:0] w_m_tdata;

  // Only beats that can be forwarded see output back-pressure; dropped beats are always accepted.
  assign w_fwd_cand = (r_state == ST_PASS) ||
                      (((r_state == ST_WAIT_SOF) || (r_state == ST_RESYNC)) && axis.s_tuser);
  assign axis.s_tready = w_fwd_cand ? w_slice_ready : 1'b1;
  assign w_accept = axis.s_tvalid && axis.s_tready;
  assign w_load   = w_accept && w_fwd_cand;

  always_comb begin
    w_state_nxt  = r_state;
    w_col_nxt    = r_col;
    w_row_nxt    = r_row;
    w_col_eff    = '0;
    w_row_eff    = '0;
    w_restart    = 1'b0;
    w_eol        = 1'b0;
    w_force_last = 1'b0;
    w_frame_end  = 1'b0;
    w_set_short  = 1'b0;
    w_set_long   = 1'b0;
    w_set_sof    = 1'b0;
    if (r_state == ST_IDLE) begin
      if (i_start) w_state_nxt = ST_WAIT_SOF;
    end else if (w_load) begin
      // A forwarded tuser outside PASS, or mid-frame in PASS, starts a fresh frame at (0,0).
      w_restart = (r_state != ST_PASS) ||
                  (axis.s_tuser && ((r_col != '0) || (r_row != '0)));
      w_set_sof = w_restart && (r_state != ST_WAIT_SOF);
      w_col_eff = w_restart ? '0 : r_col;
      w_row_eff = w_restart ? '0 : r_row;
      w_state_nxt = ST_PASS;
      if (axis.s_tlast) begin
        w_eol       = 1'b1;
        w_set_short = (w_col_eff != COL_LAST);
      end else if (w_col_eff == COL_LAST) begin
        w_eol        = 1'b1;
        w_force_last = 1'b1;
        w_set_long   = 1'b1;
        w_state_nxt  = ST_RESYNC;
      end
      if (w_eol) begin
        w_col_nxt = '0;
        if (w_row_eff == ROW_LAST) begin
          w_frame_end = 1'b1;
          w_row_nxt   = '0;
          w_state_nxt = i_continuous ? ST_WAIT_SOF : ST_IDLE;
        end else begin
          w_row_nxt = w_row_eff + ROW_W'(1);
        end
      end else begin
        w_col_nxt = w_col_eff + COL_W'(1);
        w_row_nxt = w_row_eff;
      end
    end else if ((r_state == ST_RESYNC) && w_accept && axis.s_tlast) begin
      w_state_nxt = ST_PASS;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state       <= ST_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_frame_done  <= 1'b0;
      r_err_short   <= 1'b0;
      r_err_long    <= 1'b0;
      r_err_sof     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_frame_done <= w_frame_end;
      if (w_frame_end) r_frame_count <= r_frame_count + 16'd1;
      if ((r_state == ST_IDLE) && i_start) begin
        r_err_short <= 1'b0;
        r_err_long  <= 1'b0;
        r_err_sof   <= 1'b0;
      end else begin
        if (w_set_short) r_err_short <= 1'b1;
        if (w_set_long)  r_err_long  <= 1'b1;
        if (w_set_sof)   r_err_sof   <= 1'b1;
      end
    end
  end

  pp_axis_reg_slice #(.W(DATA_W)) u_out_slice (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_load  (w_load),
    .i_data  (axis.s_tdata),
    .i_user  (axis.s_tuser),
    .i_last  (axis.s_tlast || w_force_last),
    .i_ready (axis.m_tready),
    .o_ready (w_slice_ready),
    .o_valid (w_m_tvalid),
    .o_data  (w_m_tdata),
    .o_user  (w_m_tuser),
    .o_last  (w_m_tlast)
  );

  assign axis.m_tvalid = w_m_tvalid;
  assign axis.m_tdata  = w_m_tdata;
  assign axis.m_tuser  = w_m_tuser;
  assign axis.m_tlast  = w_m_tlast;

  assign o_busy        = (r_state != ST_IDLE);
  assign o_frame_done  = r_frame_done;
  assign o_err_short   = r_err_short;
  assign o_err_long    = r_err_long;
  assign o_err_sof     = r_err_sof;
  assign o_frame_count = r_frame_count;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pp_frame_gate.sv
// Bench for pp_frame_gate on an 8x4 geometry: per-line reference model feeding an expected queue,
// monitor on the falling edge, one task per scenario.
module tb_pp_frame_gate;
  import pp_pkg::*;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        busy, frame_done, err_short, err_long, err_sof;
  logic [15:0] frame_count;
  logic [1:0]  dbg_state;

  pp_frame_gate_if #(.DATA_W(DW)) axis ();

  pp_frame_gate #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_start       (start),
    .i_continuous  (cont),
    .axis          (axis.slave),
    .o_busy        (busy),
    .o_frame_done  (frame_done),
    .o_err_short   (err_short),
    .o_err_long    (err_long),
    .o_err_sof     (err_sof),
    .o_frame_count (frame_count),
    .o_dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int out_cnt = 0;
  int exp_frames = 0;
  logic [DW+1:0] exp_q[$];
  logic rnd_ready = 1'b0;
  logic ready_level = 1'b1;

  always @(posedge clk) begin
    #1;
    axis.m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Scoreboard / protocol monitor, sampling mid-cycle.
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_beat;
  always @(negedge clk) begin
    logic [DW+1:0] cur;
    logic [DW+1:0] e;
    if (rstn) begin
      cur = {axis.m_tuser, axis.m_tlast, axis.m_tdata};
      if (prev_stall) begin
        total++;
        if (!axis.m_tvalid || cur !== prev_beat) begin
          bad++;
          $display("FAIL stall_hold got v=%0b beat=%h need v=1 beat=%h", axis.m_tvalid, cur, prev_beat);
        end
      end
      prev_stall = axis.m_tvalid && !axis.m_tready;
      prev_beat  = cur;
      if (frame_done) begin
        done_cnt++;
        total++;
        if (!(axis.m_tvalid && axis.m_tlast)) begin
          bad++;
          $display("FAIL done_align got m_tvalid=%0b m_tlast=%0b need 1 1", axis.m_tvalid, axis.m_tlast);
        end
      end
      if (axis.m_tvalid && axis.m_tready) begin
        out_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat got %h need none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            bad++;
            $display("FAIL beat got user/last/data=%h need %h", cur, e);
          end
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    axis.s_tvalid = 1'b1;
    axis.s_tdata  = d;
    axis.s_tuser  = u;
    axis.s_tlast  = l;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = axis.s_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout got s_tready=0 need 1 within 200 cycles");
    end
  endtask

  task automatic idle_cycles(input int n);
    axis.s_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: of each line of length L, the first min(L,W) beats reach the
  // detector and the last of those carries tlast; only the frame's first beat has tuser.
  task automatic send_frame(input int lens[H], input bit fwd, input bit sof, input bit gaps, input int cut);
    int sent;
    int keep;
    logic [DW-1:0] d;
    logic u, l;
    sent = 0;
    for (int j = 0; j < H; j++) begin
      keep = (lens[j] < W) ? lens[j] : W;
      for (int k = 0; k < lens[j]; k++) begin
        if (sent < cut) begin
          d = $urandom;
          u = sof && (j == 0) && (k == 0);
          l = (k == lens[j] - 1);
          if (fwd && k < keep) exp_q.push_back({u, 1'(k == keep - 1), d});
          send_beat(d, u, l);
          sent++;
          if (gaps && $urandom_range(0, 3) == 0) idle_cycles(1);
        end
      end
    end
    axis.s_tvalid = 1'b0;
  endtask

  task automatic arm();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d beats outstanding need 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    axis.s_tvalid = 1'b0;
    axis.s_tdata  = '0;
    axis.s_tuser  = 1'b0;
    axis.s_tlast  = 1'b0;
    #2;
    total++;
    if (axis.m_tvalid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got v=%0b busy=%0b done=%0b need 0 0 0", axis.m_tvalid, busy, frame_done);
    end
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({err_short, err_long, err_sof} !== 3'b000) begin
      bad++;
      $display("FAIL reset_errs got %b need 000", {err_short, err_long, err_sof});
    end
    total++;
    if (frame_count !== 16'd0 || dbg_state !== PP_IDLE) begin
      bad++;
      $display("FAIL reset_state got count=%0d state=%0d need 0 0", frame_count, dbg_state);
    end
    total++;
    if (axis.s_tready !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready got %0b need 1", axis.s_tready);
    end
  endtask

  task automatic test_clean_frame();
    int d0, o0;
    d0 = done_cnt;
    o0 = out_cnt;
    ready_level = 1'b1;
    arm();
    send_beat($urandom, 1'b0, 1'b0);
    send_beat($urandom, 1'b0, 1'b0);
    send_frame('{8, 8, 8, 8}, 1'b1, 1'b1, 1'b0, 1000);
    drain();
    exp_frames++;
    total++;
    if (out_cnt - o0 != 32) begin
      bad++;
      $display("FAIL clean_beats got %0d need 32", out_cnt - o0);
    end
    total++;
    if (done_cnt - d0 != 1 || frame_count !== 16'(exp_frames)) begin
      bad++;
      $display("FAIL clean_done got pulses=%0d count=%0d need 1 %0d", done_cnt - d0, frame_count, exp_frames);
    end
    total++;
    if (busy !== 1'b0 || {err_short, err_long, err_sof} !== 3'b000) begin
      bad++;
      $display("FAIL clean_status got busy=%0b errs=%b need 0 000", busy, {err_short, err_long, err_sof});
    end
  endtask

  task automatic test_idle_drop();
    int o0;
    o0 = out_cnt;
    send_frame('{8, 8, 8, 8}, 1'b0, 1'b1, 1'b0, 1000);
    idle_cycles(4);
    total++;
    if (out_cnt != o0 || frame_count !== 16'(exp_frames)) begin
      bad++;
      $display("FAIL idle_drop got beats=%0d count=%0d need 0 %0d", out_cnt - o0, frame_count, exp_frames);
    end
    arm();
    send_frame('{8, 8, 0, 0}, 1'b0, 1'b0, 1'b0, 1000);
    idle_cycles(3);
    total++;
    if (out_cnt != o0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL midframe_drop got beats=%0d busy=%0b need 0 1", out_cnt - o0, busy);
    end
    send_frame('{8, 8, 8, 8}, 1'b1, 1'b1, 1'b0, 1000);
    drain();
    exp_frames++;
    total++;
    if (out_cnt - o0 != 32 || frame_count !== 16'(exp_frames)) begin
      bad++;
      $display("FAIL midframe_frame got beats=%0d count=%0d need 32 %0d", out_cnt - o0, frame_count, exp_frames);
    end
  endtask

  task automatic test_short_line();
    int o0;
    o0 = out_cnt;
    arm();
    send_frame('{8, 5, 8, 8}, 1'b1, 1'b1, 1'b0, 1000);
    drain();
    exp_frames++;
    total++;
    if (out_cnt - o0 != 29 || frame_count !== 16'(exp_frames)) begin
      bad++;
      $display("FAIL short_frame got beats=%0d count=%0d need 29 %0d", out_cnt - o0, frame_count, exp_frames);
    end
    total++;
    if ({err_short, err_long, err_sof} !== 3'b100) begin
      bad++;
      $display("FAIL short_errs got %b need 100", {err_short, err_long, err_sof});
    end
  endtask

  task automatic test_long_line();
    int o0;
    o0 = out_cnt;
    arm();
    send_frame('{8, 8, 11, 8}, 1'b1, 1'b1, 1'b0, 1000);
    drain();
    exp_frames++;
    total++;
    if (out_cnt - o0 != 32 || frame_count !== 16'(exp_frames)) begin
      bad++;
      $display("FAIL long_frame got beats=%0d count=%0d need 32 %0d", out_cnt - o0, frame_count, exp_frames);
    end
    total++;
    if ({err_short, err_long, err_sof} !== 3'b010) begin
      bad++;
      $display("FAIL long_errs got %b need 010", {err_short, err_long, err_sof});
    end
  endtask

  task automatic test_sof_restart();
    logic [DW-1:0] d;
    arm();
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      exp_q.push_back({1'(k == 0), 1'b0, d});
      send_beat(d, 1'(k == 0), 1'b0);
    end
    send_frame('{8, 8, 8, 8}, 1'b1, 1'b1, 1'b0, 1000);
    drain();
    exp_frames++;
    total++;
    if ({err_short, err_long, err_sof} !== 3'b001 || frame_count !== 16'(exp_frames)) begin
      bad++;
      $display("FAIL sof_restart got errs=%b count=%0d need 001 %0d", {err_short, err_long, err_sof}, frame_count, exp_frames);
    end
  endtask

  task automatic test_random_continuous();
    int d0, o0;
    d0 = done_cnt;
    o0 = out_cnt;
    rnd_ready = 1'b1;
    cont = 1'b1;
    arm();
    send_frame('{8, 8, 8, 8}, 1'b1, 1'b1, 1'b1, 1000);
    idle_cycles($urandom_range(0, 3));
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL cont_rearm got busy=%0b need 1", busy);
    end
    send_frame('{8, 8, 8, 8}, 1'b1, 1'b1, 1'b1, 1000);
    cont = 1'b0;
    send_frame('{8, 8, 8, 8}, 1'b1, 1'b1, 1'b1, 1000);
    drain();
    rnd_ready = 1'b0;
    exp_frames += 3;
    total++;
    if (out_cnt - o0 != 96 || done_cnt - d0 != 3) begin
      bad++;
      $display("FAIL cont_totals got beats=%0d pulses=%0d need 96 3", out_cnt - o0, done_cnt - d0);
    end
    total++;
    if (frame_count !== 16'(exp_frames) || busy !== 1'b0) begin
      bad++;
      $display("FAIL cont_end got count=%0d busy=%0b need %0d 0", frame_count, busy, exp_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    int d0, o0;
    d0 = done_cnt;
    ready_level = 1'b1;
    arm();
    send_frame('{8, 8, 8, 8}, 1'b1, 1'b1, 1'b0, 19);
    rstn = 1'b0;
    #1;
    total++;
    if (axis.m_tvalid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd0 || dbg_state !== PP_IDLE) begin
      bad++;
      $display("FAIL reset_mid got v=%0b busy=%0b count=%0d state=%0d need 0 0 0 0", axis.m_tvalid, busy, frame_count, dbg_state);
    end
    exp_q.delete();
    exp_frames = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (done_cnt != d0) begin
      bad++;
      $display("FAIL reset_no_done got pulses=%0d need 0", done_cnt - d0);
    end
    o0 = out_cnt;
    arm();
    send_frame('{8, 8, 8, 8}, 1'b1, 1'b1, 1'b0, 1000);
    drain();
    exp_frames++;
    total++;
    if (out_cnt - o0 != 32 || frame_count !== 16'(exp_frames) || done_cnt - d0 != 1) begin
      bad++;
      $display("FAIL rearm_after_reset got beats=%0d count=%0d pulses=%0d need 32 1 1", out_cnt - o0, frame_count, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_idle_drop();
    test_short_line();
    test_long_line();
    test_sof_restart();
    test_random_continuous();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
